// File: rtl/rat_add_sub_arb_if.sv
// -----------------------------------------------------------------------------
// rat_add_sub_arb_if
// Request/response bundle between the rational ALU front-ends and the shared
// add_sub arbiter.
//   req_valid/req_ready : per-requester handshake (ready is one-hot or zero)
//   req_sub             : per-requester op select, 1 = l - r, 0 = l + r
//   req_{l,r}_{num,den} : packed operands, requester i at [i*WIDTH +: WIDTH]
//   rsp_valid/rsp_ready : shared response handshake
//   rsp_id              : index of the requester that issued the operation
//   rsp_num/rsp_den     : result fraction
// Modports: master = requester side, slave = arbiter side.
// -----------------------------------------------------------------------------
interface rat_add_sub_arb_if #(
  parameter int WIDTH = 32,
  parameter int NREQ  = 4,
  parameter int IDW   = 2
);
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ-1:0]       req_sub;
  logic [NREQ*WIDTH-1:0] req_l_num;
  logic [NREQ*WIDTH-1:0] req_l_den;
  logic [NREQ*WIDTH-1:0] req_r_num;
  logic [NREQ*WIDTH-1:0] req_r_den;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [IDW-1:0]        rsp_id;
  logic [WIDTH-1:0]      rsp_num;
  logic [WIDTH-1:0]      rsp_den;

  modport master (
    output req_valid, req_sub, req_l_num, req_l_den, req_r_num, req_r_den,
    input  req_ready,
    input  rsp_valid, rsp_id, rsp_num, rsp_den,
    output rsp_ready
  );

  modport slave (
    input  req_valid, req_sub, req_l_num, req_l_den, req_r_num, req_r_den,
    output req_ready,
    output rsp_valid, rsp_id, rsp_num, rsp_den,
    input  rsp_ready
  );
endinterface

// File: rtl/rat_add_sub_arb.sv
// -----------------------------------------------------------------------------
// rat_add_sub_arb
// Round-robin arbiter/sequencer sharing one rational add_sub core among NREQ
// requesters. One operation at a time: grant (IDLE), hold operands on the core
// for at least CORE_LAT cycles until core_rdy_i (RUN), present the result on the
// shared response channel until accepted (RSP).
// Ports:
//   clk, rst          : clock (rising edge), asynchronous active-high reset
//   bus (slave)       : request/response bundle, see rat_add_sub_arb_if
//   core_sub_o        : enable_sub to the core
//   core_{l,r}_{num,den}_o : registered core operands
//   core_s_num_i, core_s_den_i, core_rdy_i : core result and result-valid
//   busy_o            : high while in RUN or RSP
//   rsp_err_o         : zero-denominator flag (only with the option below)
// Option macro: RAT_ARB_ZERO_DEN_CHK_EN -- when defined, a grant with a zero
// denominator bypasses the core and answers 0/0 with rsp_err_o = 1.
// -----------------------------------------------------------------------------
module rat_add_sub_arb #(
  parameter int WIDTH    = 32,
  parameter int NREQ     = 4,
  parameter int IDW      = 2,
  parameter int CORE_LAT = 2
) (
  input  logic             clk,
  input  logic             rst,
  rat_add_sub_arb_if.slave bus,
  output logic             core_sub_o,
  output logic [WIDTH-1:0] core_l_num_o,
  output logic [WIDTH-1:0] core_l_den_o,
  output logic [WIDTH-1:0] core_r_num_o,
  output logic [WIDTH-1:0] core_r_den_o,
  input  logic [WIDTH-1:0] core_s_num_i,
  input  logic [WIDTH-1:0] core_s_den_i,
  input  logic             core_rdy_i,
  output logic             busy_o
`ifdef RAT_ARB_ZERO_DEN_CHK_EN
  ,
  output logic             rsp_err_o
`endif
);

  localparam int CNTW = (CORE_LAT > 1) ? $clog2(CORE_LAT) : 1;
  localparam logic [CNTW-1:0] CNT_LAST = CNTW'(CORE_LAT - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_RSP  = 2'd2
  } state_t;

  state_t           state_q;
  logic [IDW-1:0]   rr_ptr_q;
  logic [IDW-1:0]   tag_q;
  logic [CNTW-1:0]  cnt_q;
  logic             core_sub_q;
  logic [WIDTH-1:0] core_l_num_q;
  logic [WIDTH-1:0] core_l_den_q;
  logic [WIDTH-1:0] core_r_num_q;
  logic [WIDTH-1:0] core_r_den_q;
  logic             rsp_valid_q;
  logic [IDW-1:0]   rsp_id_q;
  logic [WIDTH-1:0] rsp_num_q;
  logic [WIDTH-1:0] rsp_den_q;
`ifdef RAT_ARB_ZERO_DEN_CHK_EN
  logic             rsp_err_q;
`endif

  logic             gnt_any_s;
  logic [IDW-1:0]   gnt_idx_s;
  logic [NREQ-1:0]  ready_s;
  logic             fire_s;
  logic             zero_den_s;
  logic             sel_sub_s;
  logic [WIDTH-1:0] sel_l_num_s;
  logic [WIDTH-1:0] sel_l_den_s;
  logic [WIDTH-1:0] sel_r_num_s;
  logic [WIDTH-1:0] sel_r_den_s;

  // Round-robin search: first valid requester after rr_ptr_q, wrapping mod NREQ.
  always_comb begin
    int idx;
    gnt_any_s = 1'b0;
    gnt_idx_s = '0;
    idx       = 0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = (int'(rr_ptr_q) + k) % NREQ;
      if (!gnt_any_s && bus.req_valid[idx]) begin
        gnt_any_s = 1'b1;
        gnt_idx_s = IDW'(idx);
      end else begin
        gnt_any_s = gnt_any_s;
      end
    end
  end

  // Combinational one-hot accept, only offered in IDLE and never during reset.
  always_comb begin
    ready_s = '0;
    if ((state_q == ST_IDLE) && gnt_any_s && !rst) begin
      ready_s[gnt_idx_s] = 1'b1;
    end else begin
      ready_s = '0;
    end
  end

  // Operand mux for the granted requester plus the optional zero-denominator test.
  always_comb begin
    fire_s      = (state_q == ST_IDLE) && gnt_any_s;
    sel_sub_s   = bus.req_sub[gnt_idx_s];
    sel_l_num_s = bus.req_l_num[gnt_idx_s*WIDTH +: WIDTH];
    sel_l_den_s = bus.req_l_den[gnt_idx_s*WIDTH +: WIDTH];
    sel_r_num_s = bus.req_r_num[gnt_idx_s*WIDTH +: WIDTH];
    sel_r_den_s = bus.req_r_den[gnt_idx_s*WIDTH +: WIDTH];
`ifdef RAT_ARB_ZERO_DEN_CHK_EN
    zero_den_s  = (sel_l_den_s == '0) || (sel_r_den_s == '0);
`else
    zero_den_s  = 1'b0;
`endif
  end

  // Sequencer FSM: grant/latch, wait on core, hold response until accepted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      rr_ptr_q     <= IDW'(NREQ - 1);
      tag_q        <= '0;
      cnt_q        <= '0;
      core_sub_q   <= 1'b0;
      core_l_num_q <= '0;
      core_l_den_q <= '0;
      core_r_num_q <= '0;
      core_r_den_q <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= '0;
      rsp_num_q    <= '0;
      rsp_den_q    <= '0;
`ifdef RAT_ARB_ZERO_DEN_CHK_EN
      rsp_err_q    <= 1'b0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (fire_s) begin
            rr_ptr_q <= gnt_idx_s;
            tag_q    <= gnt_idx_s;
            cnt_q    <= '0;
            if (zero_den_s) begin
              // Answer directly; the core keeps its previous operands.
              rsp_valid_q <= 1'b1;
              rsp_id_q    <= gnt_idx_s;
              rsp_num_q   <= '0;
              rsp_den_q   <= '0;
`ifdef RAT_ARB_ZERO_DEN_CHK_EN
              rsp_err_q   <= 1'b1;
`endif
              state_q     <= ST_RSP;
            end else begin
              core_sub_q   <= sel_sub_s;
              core_l_num_q <= sel_l_num_s;
              core_l_den_q <= sel_l_den_s;
              core_r_num_q <= sel_r_num_s;
              core_r_den_q <= sel_r_den_s;
              state_q      <= ST_RUN;
            end
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_RUN: begin
          if ((cnt_q == CNT_LAST) && core_rdy_i) begin
            rsp_valid_q <= 1'b1;
            rsp_id_q    <= tag_q;
            rsp_num_q   <= core_s_num_i;
            rsp_den_q   <= core_s_den_i;
`ifdef RAT_ARB_ZERO_DEN_CHK_EN
            rsp_err_q   <= 1'b0;
`endif
            state_q     <= ST_RSP;
          end else if (cnt_q != CNT_LAST) begin
            cnt_q <= cnt_q + CNTW'(1);
          end else begin
            cnt_q <= cnt_q;
          end
        end
        ST_RSP: begin
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state_q     <= ST_IDLE;
          end else begin
            rsp_valid_q <= rsp_valid_q;
          end
        end
        default: begin
          state_q     <= ST_IDLE;
          rsp_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.req_ready = ready_s;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_num   = rsp_num_q;
  assign bus.rsp_den   = rsp_den_q;
  assign core_sub_o    = core_sub_q;
  assign core_l_num_o  = core_l_num_q;
  assign core_l_den_o  = core_l_den_q;
  assign core_r_num_o  = core_r_num_q;
  assign core_r_den_o  = core_r_den_q;
  assign busy_o        = (state_q != ST_IDLE);
`ifdef RAT_ARB_ZERO_DEN_CHK_EN
  assign rsp_err_o     = rsp_err_q;
`endif

endmodule

// File: tb/tb_rat_add_sub_arb.sv
module tb_rat_add_sub_arb;
  localparam int WIDTH = 32;
  localparam int NREQ  = 4;
  localparam int IDW   = 2;

  typedef struct {
    logic [IDW-1:0]   id;
    logic [WIDTH-1:0] num;
    logic [WIDTH-1:0] den;
  } exp_t;

  logic clk;
  logic rst;
  logic core_sub;
  logic [WIDTH-1:0] core_l_num, core_l_den, core_r_num, core_r_den;
  logic [WIDTH-1:0] core_s_num_q, core_s_den_q;
  logic core_rdy_q;
  logic core_hold;
  logic core_rdy;
  logic busy;
`ifdef RAT_ARB_ZERO_DEN_CHK_EN
  logic rsp_err;
`endif

  int tests;
  int fails;
  exp_t sb[$];

  rat_add_sub_arb_if #(.WIDTH(WIDTH), .NREQ(NREQ), .IDW(IDW)) bus_if ();

  rat_add_sub_arb #(.WIDTH(WIDTH), .NREQ(NREQ), .IDW(IDW), .CORE_LAT(2)) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus_if),
    .core_sub_o   (core_sub),
    .core_l_num_o (core_l_num),
    .core_l_den_o (core_l_den),
    .core_r_num_o (core_r_num),
    .core_r_den_o (core_r_den),
    .core_s_num_i (core_s_num_q),
    .core_s_den_i (core_s_den_q),
    .core_rdy_i   (core_rdy),
    .busy_o       (busy)
`ifdef RAT_ARB_ZERO_DEN_CHK_EN
    ,
    .rsp_err_o    (rsp_err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Registered core model: result one cycle after the operands, rdy can be forced low.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      core_s_num_q <= '0;
      core_s_den_q <= '0;
      core_rdy_q   <= 1'b0;
    end else begin
      core_s_num_q <= core_sub ? (core_l_num * core_r_den - core_r_num * core_l_den)
                               : (core_l_num * core_r_den + core_r_num * core_l_den);
      core_s_den_q <= core_l_den * core_r_den;
      core_rdy_q   <= 1'b1;
    end
  end
  assign core_rdy = core_rdy_q & ~core_hold;

  function automatic exp_t ref_op(input logic [IDW-1:0] id, input logic sub,
                                  input logic [WIDTH-1:0] ln, input logic [WIDTH-1:0] ld,
                                  input logic [WIDTH-1:0] rn, input logic [WIDTH-1:0] rd);
    exp_t e;
    e.id  = id;
    e.num = sub ? (ln * rd - rn * ld) : (ln * rd + rn * ld);
    e.den = ld * rd;
    return e;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic set_req(input int i, input logic sub, input logic [WIDTH-1:0] ln,
                         input logic [WIDTH-1:0] ld, input logic [WIDTH-1:0] rn,
                         input logic [WIDTH-1:0] rd);
    bus_if.req_sub[i]                  = sub;
    bus_if.req_l_num[i*WIDTH +: WIDTH] = ln;
    bus_if.req_l_den[i*WIDTH +: WIDTH] = ld;
    bus_if.req_r_num[i*WIDTH +: WIDTH] = rn;
    bus_if.req_r_den[i*WIDTH +: WIDTH] = rd;
  endtask

  task automatic wait_rsp(input int max_cyc, output int n);
    n = 0;
    while (bus_if.rsp_valid !== 1'b1 && n < max_cyc) begin
      @(negedge clk);
      n++;
    end
    chk("rsp_seen", 64'(bus_if.rsp_valid), 64'd1);
  endtask

  task automatic chk_rsp(input string tag);
    exp_t e;
    chk({tag, "_sb_has"}, 64'(sb.size() > 0), 64'd1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk({tag, "_id"},  64'(bus_if.rsp_id),  64'(e.id));
      chk({tag, "_num"}, 64'(bus_if.rsp_num), 64'(e.num));
      chk({tag, "_den"}, 64'(bus_if.rsp_den), 64'(e.den));
    end
  endtask

  task automatic handshake(input string tag);
    bus_if.rsp_ready = 1'b1;
    @(negedge clk);
    bus_if.rsp_ready = 1'b0;
    chk({tag, "_rsp_drop"}, 64'(bus_if.rsp_valid), 64'd0);
    chk({tag, "_busy_drop"}, 64'(busy), 64'd0);
  endtask

  initial begin
    int n;
    int cyc;
    int last;
    int gcount;
    int rcount;
    int order [5];
    order = '{0, 1, 2, 3, 0};
    tests = 0;
    fails = 0;
    rst = 1'b1;
    core_hold = 1'b0;
    bus_if.req_valid = 4'b0101;
    bus_if.req_sub   = '0;
    bus_if.req_l_num = '0;
    bus_if.req_l_den = '0;
    bus_if.req_r_num = '0;
    bus_if.req_r_den = '0;
    bus_if.rsp_ready = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_ready", 64'(bus_if.req_ready), 64'd0);
    chk("rst_rsp_valid", 64'(bus_if.rsp_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_core_l_num", 64'(core_l_num), 64'd0);
    chk("rst_core_sub", 64'(core_sub), 64'd0);
    chk("rst_rsp_id", 64'(bus_if.rsp_id), 64'd0);
    chk("rst_rsp_num", 64'(bus_if.rsp_num), 64'd0);
    chk("rst_rsp_den", 64'(bus_if.rsp_den), 64'd0);
    bus_if.req_valid = '0;
    rst = 1'b0;
    @(negedge clk);

    // T1: requester 2, 3/4 + 5/6
    set_req(2, 1'b0, 32'd3, 32'd4, 32'd5, 32'd6);
    bus_if.req_valid[2] = 1'b1;
    #1;
    chk("t1_ready", 64'(bus_if.req_ready), 64'h4);
    chk("t1_busy_idle", 64'(busy), 64'd0);
    sb.push_back('{2'd2, 32'd38, 32'd24});
    @(negedge clk);
    bus_if.req_valid = '0;
    set_req(2, 1'b1, 32'd9, 32'd9, 32'd9, 32'd9);
    #1;
    chk("t1_ready_drop", 64'(bus_if.req_ready), 64'd0);
    chk("t1_busy", 64'(busy), 64'd1);
    chk("t1_core_l_num", 64'(core_l_num), 64'd3);
    chk("t1_core_r_den", 64'(core_r_den), 64'd6);
    chk("t1_core_sub", 64'(core_sub), 64'd0);
    wait_rsp(10, n);
    chk("t1_latency", 64'(n), 64'd2);
    chk_rsp("t1");
    chk("t1_busy_rsp", 64'(busy), 64'd1);
    handshake("t1");

    // T2: requester 0, 1/2 - 1/3
    set_req(0, 1'b1, 32'd1, 32'd2, 32'd1, 32'd3);
    bus_if.req_valid[0] = 1'b1;
    #1;
    chk("t2_ready", 64'(bus_if.req_ready), 64'h1);
    sb.push_back('{2'd0, 32'd1, 32'd6});
    @(negedge clk);
    bus_if.req_valid = '0;
    wait_rsp(10, n);
    chk("t2_latency", 64'(n), 64'd2);
    chk_rsp("t2");
    handshake("t2");

    // T3: round robin with all requesters held valid from reset
    rst = 1'b1;
    for (int i = 0; i < NREQ; i++) begin
      set_req(i, 1'b0, WIDTH'(i + 1), WIDTH'(i + 2), 32'd1, 32'd3);
    end
    for (int g = 0; g < 5; g++) begin
      sb.push_back(ref_op(IDW'(order[g]), 1'b0, WIDTH'(order[g] + 1),
                          WIDTH'(order[g] + 2), 32'd1, 32'd3));
    end
    bus_if.req_valid = 4'hF;
    bus_if.rsp_ready = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    cyc = 0; last = 0; gcount = 0; rcount = 0;
    while (rcount < 5 && cyc < 60) begin
      #1;
      if (bus_if.req_ready != '0) begin
        chk("t3_grant", 64'(bus_if.req_ready), 64'(4'b0001 << order[gcount % 5]));
        if (gcount > 0) chk("t3_gap", 64'(cyc - last), 64'd4);
        last = cyc;
        gcount++;
        if (gcount == 5) begin
          @(posedge clk);
          #1;
          bus_if.req_valid = '0;
        end
      end
      if (bus_if.rsp_valid === 1'b1) begin
        chk_rsp("t3");
        rcount++;
      end
      @(negedge clk);
      cyc++;
    end
    chk("t3_responses", 64'(rcount), 64'd5);
    chk("t3_grants", 64'(gcount), 64'd5);
    bus_if.rsp_ready = 1'b0;

    // T4: backpressure with pending requests
    set_req(1, 1'b1, 32'd7, 32'd8, 32'd1, 32'd4);
    set_req(3, 1'b0, 32'd1, 32'd5, 32'd2, 32'd5);
    bus_if.req_valid = 4'b1010;
    #1;
    chk("t4_ready1", 64'(bus_if.req_ready), 64'h2);
    sb.push_back('{2'd1, 32'd20, 32'd32});
    sb.push_back('{2'd3, 32'd15, 32'd25});
    @(negedge clk);
    bus_if.req_valid[1] = 1'b0;
    wait_rsp(10, n);
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("t4_hold_valid", 64'(bus_if.rsp_valid), 64'd1);
      chk("t4_hold_num", 64'(bus_if.rsp_num), 64'd20);
      chk("t4_no_grant", 64'(bus_if.req_ready), 64'd0);
      @(negedge clk);
    end
    chk_rsp("t4a");
    bus_if.rsp_ready = 1'b1;
    @(negedge clk);
    bus_if.rsp_ready = 1'b0;
    #1;
    chk("t4_regrant", 64'(bus_if.req_ready), 64'h8);
    chk("t4_rsp_drop", 64'(bus_if.rsp_valid), 64'd0);
    @(negedge clk);
    bus_if.req_valid = '0;
    chk("t4_busy", 64'(busy), 64'd1);
    wait_rsp(10, n);
    chk_rsp("t4b");
    handshake("t4b");

    // T5: slow core
    set_req(2, 1'b0, 32'd1, 32'd2, 32'd1, 32'd2);
    core_hold = 1'b1;
    bus_if.req_valid[2] = 1'b1;
    #1;
    chk("t5_ready", 64'(bus_if.req_ready), 64'h4);
    sb.push_back('{2'd2, 32'd4, 32'd4});
    @(negedge clk);
    bus_if.req_valid = '0;
    set_req(2, 1'b1, 32'd5, 32'd5, 32'd5, 32'd5);
    for (int k = 0; k < 6; k++) begin
      chk("t5_busy", 64'(busy), 64'd1);
      chk("t5_no_rsp", 64'(bus_if.rsp_valid), 64'd0);
      chk("t5_l_num", 64'(core_l_num), 64'd1);
      chk("t5_l_den", 64'(core_l_den), 64'd2);
      @(negedge clk);
    end
    core_hold = 1'b0;
    @(negedge clk);
    chk("t5_rsp_now", 64'(bus_if.rsp_valid), 64'd1);
    chk_rsp("t5");
    handshake("t5");

    // T6: asynchronous reset in RUN
    set_req(0, 1'b1, 32'd1, 32'd2, 32'd3, 32'd4);
    bus_if.req_valid[0] = 1'b1;
    #1;
    chk("t6_ready", 64'(bus_if.req_ready), 64'h1);
    @(negedge clk);
    chk("t6_busy", 64'(busy), 64'd1);
    chk("t6_l_num", 64'(core_l_num), 64'd1);
    chk("t6_sub", 64'(core_sub), 64'd1);
    #3;
    rst = 1'b1;
    #1;
    chk("t6_rst_rsp_valid", 64'(bus_if.rsp_valid), 64'd0);
    chk("t6_rst_busy", 64'(busy), 64'd0);
    chk("t6_rst_l_num", 64'(core_l_num), 64'd0);
    chk("t6_rst_r_den", 64'(core_r_den), 64'd0);
    chk("t6_rst_sub", 64'(core_sub), 64'd0);
    chk("t6_rst_ready", 64'(bus_if.req_ready), 64'd0);
    @(negedge clk);
    bus_if.req_valid = '0;
    rst = 1'b0;
    @(negedge clk);
    chk("t6_idle_after", 64'(busy), 64'd0);

`ifdef RAT_ARB_ZERO_DEN_CHK_EN
    // Zero denominator bypass
    set_req(1, 1'b0, 32'd1, 32'd0, 32'd2, 32'd3);
    bus_if.req_valid[1] = 1'b1;
    #1;
    chk("zd_ready", 64'(bus_if.req_ready), 64'h2);
    @(negedge clk);
    bus_if.req_valid = '0;
    chk("zd_rsp_valid", 64'(bus_if.rsp_valid), 64'd1);
    chk("zd_err", 64'(rsp_err), 64'd1);
    chk("zd_num", 64'(bus_if.rsp_num), 64'd0);
    chk("zd_den", 64'(bus_if.rsp_den), 64'd0);
    chk("zd_id", 64'(bus_if.rsp_id), 64'd1);
    chk("zd_core_untouched", 64'(core_l_num), 64'd0);
    handshake("zd");
`endif

    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
